// File: rtl/shift_sequencer_pkg.sv
// Shared types for the shift sequencer: FSM state encoding and shift direction codes.
// Imported by the sequencer top and the barrel shifter it drives.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } shift_seq_state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_sequencer_if.sv
// Command and result handshake bundle for shift_sequencer.
// The master drives commands and takes results; the slave is the sequencer.
interface shift_sequencer_if #(
  parameter int WIDTH = 12,
  parameter int AMT_W = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_dir;
  logic [AMT_W-1:0] in_amt;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [AMT_W-1:0] out_steps;

  modport master (
    output in_valid, in_data, in_dir, in_amt, out_ready,
    input  in_ready, out_valid, out_data, out_steps
  );

  modport slave (
    input  in_valid, in_data, in_dir, in_amt, out_ready,
    output in_ready, out_valid, out_data, out_steps
  );

endinterface

// File: rtl/shift_sequencer_barrel.sv
// Single-pass logical barrel shifter, left or right by 0..WIDTH-1.
// Purely combinational, zero latency; no backpressure.
// Vacated bit positions are filled with zeros in both directions.
module Barrel_shifter
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 12,
  localparam int SH_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  logic             dir,
  input  logic [SH_W-1:0]  amt,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = data << amt;
    if (dir == DIR_RIGHT) begin
      result = data >> amt;
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Iterative front-end for Barrel_shifter: splits a wide shift amount into WIDTH-1 chunks.
// Latency ceil(amt/(WIDTH-1)) cycles after accept; out_valid then holds the result.
// Backpressure: result held stable until out_ready; in_ready only high in IDLE.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int AMT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  shift_sequencer_if.slave bus
);

  localparam int SH_W = $clog2(WIDTH);
  localparam logic [AMT_W-1:0] MAX_CHUNK_AMT = AMT_W'(WIDTH - 1);
  localparam logic [SH_W-1:0]  MAX_CHUNK_SH  = SH_W'(WIDTH - 1);

  shift_seq_state_e state_q;
  shift_seq_state_e state_d;

  logic [WIDTH-1:0] data_q;
  logic             dir_q;
  logic [AMT_W-1:0] rem_q;
  logic [AMT_W-1:0] steps_q;

  logic [SH_W-1:0]  chunk;
  logic [WIDTH-1:0] shifted;
  logic             accept;
  logic             last_chunk;

  assign accept     = bus.in_valid && (state_q == IDLE);
  assign last_chunk = (rem_q <= MAX_CHUNK_AMT);
  assign chunk      = last_chunk ? rem_q[SH_W-1:0] : MAX_CHUNK_SH;

  Barrel_shifter #(
    .WIDTH (WIDTH)
  ) u_barrel (
    .data   (data_q),
    .dir    (dir_q),
    .amt    (chunk),
    .result (shifted)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (bus.in_amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (last_chunk) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from registered state only, so in_ready never sees out_ready
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.out_data  = data_q;
    bus.out_steps = steps_q;
  end

  // Datapath: data/rem/steps advance one chunk per SHIFT cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      dir_q   <= 1'b0;
      rem_q   <= '0;
      steps_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            data_q  <= bus.in_data;
            dir_q   <= bus.in_dir;
            rem_q   <= bus.in_amt;
            steps_q <= '0;
          end
        end
        SHIFT: begin
          data_q  <= shifted;
          rem_q   <= rem_q - AMT_W'(chunk);
          steps_q <= steps_q + AMT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized and directed bench for shift_sequencer against a whole-shift reference model.
module tb_shift_sequencer;

  localparam int WIDTH = 12;
  localparam int AMT_W = 8;

  logic clk;
  logic rst_n;

  shift_sequencer_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

  shift_sequencer #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Whole shift in one step: amounts of WIDTH or more clear every bit.
  function automatic logic [WIDTH-1:0] ref_result(input logic [WIDTH-1:0] d, input logic dir,
                                                  input int amt);
    logic [WIDTH-1:0] r;
    r = '0;
    if (amt < WIDTH) begin
      r = dir ? (d >> amt) : (d << amt);
    end
    return r;
  endfunction

  function automatic int ref_steps(input int amt);
    return (amt + WIDTH - 2) / (WIDTH - 1);
  endfunction

  task automatic run_cmd(input logic [WIDTH-1:0] d, input logic dir, input int amt,
                         input int hold, input bit pulse);
    logic [WIDTH-1:0] exp_d;
    logic [WIDTH-1:0] held;
    int exp_n;
    int lat;
    exp_d = ref_result(d, dir, amt);
    exp_n = ref_steps(amt);

    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_dir   = dir;
    bus.in_amt   = AMT_W'(amt);
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = WIDTH'($urandom);
    bus.in_dir   = 1'($urandom);
    bus.in_amt   = AMT_W'($urandom);

    lat = 0;
    forever begin
      @(negedge clk);
      if (bus.out_valid) break;
      check("in_ready_busy", 32'(bus.in_ready), 32'd0);
      if (pulse) bus.in_valid = 1'($urandom_range(0, 1));
      lat++;
      if (lat > 4 * (1 << AMT_W)) begin
        check("out_valid_timeout", 32'(lat), 32'(exp_n));
        break;
      end
    end
    bus.in_valid = 1'b0;
    check("latency", 32'(lat), 32'(exp_n));
    check("out_data", 32'(bus.out_data), 32'(exp_d));
    check("out_steps", 32'(bus.out_steps), 32'(exp_n));

    held = bus.out_data;
    for (int i = 0; i < hold; i++) begin
      if (pulse) bus.in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_data", 32'(bus.out_data), 32'(held));
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("post_take_valid", 32'(bus.out_valid), 32'd0);
    check("post_take_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_dir    = 1'b0;
    bus.in_amt    = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_steps", 32'(bus.out_steps), 32'd0);
    rst_n = 1'b1;

    run_cmd(12'b010111001110, 1'b0, 4, 0, 1'b0);
    run_cmd(12'hA5C, 1'b1, 5, 0, 1'b0);
    run_cmd(12'hFFF, 1'b0, 22, 1, 1'b0);
    run_cmd(12'hFFF, 1'b0, 11, 0, 1'b0);
    run_cmd(12'hFFF, 1'b1, 25, 0, 1'b1);
    run_cmd(12'h3C5, 1'b0, 0, 5, 1'b1);
    run_cmd(12'hABC, 1'b1, 12, 0, 1'b0);
    run_cmd(12'h801, 1'b0, 255, 2, 1'b1);

    // Abort a right-25 command during its second SHIFT cycle
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 12'hFFF;
    bus.in_dir   = 1'b1;
    bus.in_amt   = 8'd25;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_out_steps", 32'(bus.out_steps), 32'd0);
    check("abort_out_data", 32'(bus.out_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_cmd(12'h001, 1'b0, 1, 0, 1'b0);

    for (int n = 0; n < 120; n++) begin
      int amt;
      amt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                        : int'($urandom_range(0, 2 * WIDTH));
      run_cmd(WIDTH'($urandom), 1'($urandom), amt, int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Iterative front-end for the combinational Barrel_shifter.
- Accepts a shift command (data, direction, total amount) over a valid/ready handshake.
- The total amount may exceed the barrel shifter's single-pass range. The block splits it into chunks of at most WIDTH-1 and applies one chunk per clock through an instantiated Barrel_shifter.
- Presents the final result on a valid/ready output port.
- Sits directly upstream of Barrel_shifter and owns all sequencing around it.

Parameters:
- WIDTH, 12, data width; must be >= 2. Passed to Barrel_shifter.
- AMT_W, 8, width of the total shift amount on the command port.
- SH_W, $clog2(WIDTH), derived localparam; width of the per-chunk shift amount. Not overridable.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  command valid.
- in_ready  out  1  block can accept a command.
- in_data  in  WIDTH  operand.
- in_dir  in  1  0 = logical left, 1 = logical right (same encoding as Barrel_shifter dir).
- in_amt  in  AMT_W  total shift amount, 0..2^AMT_W-1.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  shifted result.
- out_steps  out  AMT_W  number of chunks applied for this result.

Behaviour:
- Reset (async assert, sync deassert inside clk domain):
  - state=IDLE, in_ready=1, out_valid=0, out_data=0, out_steps=0.
  - Internal data register, direction register and remaining-amount register all = 0.
- FSM states: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE), registered-state decode; no combinational path from out_ready.
- IDLE:
  - On in_valid&&in_ready: capture data, dir and rem=in_amt; clear steps.
  - Next state = DONE if in_amt==0, else SHIFT.
- SHIFT, each cycle:
  - chunk = (rem > WIDTH-1) ? WIDTH-1 : rem[SH_W-1:0].
  - Feed Barrel_shifter with data register, dir register and chunk.
  - data <= shifter output; rem <= rem - chunk; steps <= steps + 1.
  - If rem <= WIDTH-1, next state = DONE; else stay in SHIFT.
- DONE:
  - out_valid=1; out_data and out_steps come directly from registers and are stable while out_valid && !out_ready.
  - On out_ready, next state = IDLE.
  - A new command cannot be accepted in the same cycle the result is taken (in_ready=0 in DONE).
- Latency:
  - N = ceil(in_amt/(WIDTH-1)).
  - out_valid is high N rising edges after the accepting edge.
  - in_amt==0 gives N=0: out_valid is high in the cycle immediately after the accepting edge, out_data=in_data, out_steps=0.
- Throughput: one command per N+2 cycles minimum (accept, N shift cycles, DONE handshake).
- Amount >= WIDTH: no special-casing; iteration naturally yields 0 for logical shifts. Latency still follows the N formula.
- Max in_amt (255 at defaults): N=24 for WIDTH=12; steps counter cannot overflow because N <= 2^AMT_W-1.
- Inputs while busy: in_valid is ignored outside IDLE; in_data/in_dir/in_amt may change freely after acceptance.
- Reset mid-operation: the command is abandoned, all state returns to reset values immediately (async), and no partial result is emitted.
- Arithmetic:
  - rem is AMT_W bits unsigned; the subtraction never underflows because chunk <= rem.
  - The chunk fits SH_W because WIDTH-1 <= 2^SH_W-1.

Decomposition:
- Package shift_seq_pkg holds:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} shift_seq_state_e;
  - the direction constants DIR_LEFT=1'b0 and DIR_RIGHT=1'b1.
- Sub-module: one instance of the existing Barrel_shifter #(.WIDTH(WIDTH)); no other sub-modules.

Test Plan (WIDTH=12, AMT_W=8):
- Left 4 on 12'b010111001110: out_data=12'b110011100000, out_steps=1, out_valid 1 edge after accept.
- Right 5 on 12'hA5C: out_data=12'h052, out_steps=1.
- Left 22 on 12'hFFF (chunks 11,11): out_data=12'h000, out_steps=2; left 11 on 12'hFFF: out_data=12'h800, out_steps=1.
- Right 25 on 12'hFFF (chunks 11,11,3): out_valid 3 edges after accept, out_data=0, out_steps=3; in_ready=0 throughout.
- Amount 0 on 12'h3C5: out_valid in the cycle after accept, out_data=12'h3C5, out_steps=0. Then hold out_ready=0 for 5 cycles: out_data is stable, in_ready=0, and in_valid pulses are ignored.
- Assert rst_n=0 during the second SHIFT cycle of a 25-bit right shift: out_valid=0 and in_ready=1 immediately. A following left 1 on 12'h001 gives 12'h002.
